// File: rtl/rvcpu_bus_pkg.sv
// Shared types and constants for the RVCPU system-bus arbiter.
// Grant is one-hot (bit 0 = master 0, bit 1 = master 1).
package rvcpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  localparam int                CTRL_W    = 3;
  localparam logic [CTRL_W-1:0] CTRL_NONE = 3'b000;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // A request with neither read nor write control never touches the bus.
  function automatic logic is_null_req(input logic [CTRL_W-1:0] rd,
                                       input logic [CTRL_W-1:0] wr);
    return (rd == CTRL_NONE) && (wr == CTRL_NONE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the master other than 'last' wins.
// 'last' = 0 means master 0 was served most recently, 1 means master 1.
module rr_arb2
  import rvcpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = last ? GNT_M0 : GNT_M1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Shares the system_bus master port between two requesters, one transaction
// at a time, with round-robin arbitration and a bus-response timeout.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// BUSY  | bus driven from registers, waiting for bus_valid or timeout
// RESP  | one-cycle ack to the granted master, bus ctrl cleared
module sys_bus_arbiter
  import rvcpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  input  logic [CTRL_W-1:0] m0_rd_ctrl,
  input  logic [CTRL_W-1:0] m0_wr_ctrl,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  input  logic [CTRL_W-1:0] m1_rd_ctrl,
  input  logic [CTRL_W-1:0] m1_wr_ctrl,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_din,
  output logic [CTRL_W-1:0] bus_rd_ctrl,
  output logic [CTRL_W-1:0] bus_wr_ctrl,
  input  logic [DATA_W-1:0] bus_dout,
  input  logic              bus_valid,
  output logic [1:0]        grant
);

  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_TC  = 8'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [CTRL_W-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [CTRL_W-1:0] sel_rd;
  logic [CTRL_W-1:0] sel_wr;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign sel_addr = gnt[1] ? m1_addr    : m0_addr;
  assign sel_din  = gnt[1] ? m1_din     : m0_din;
  assign sel_rd   = gnt[1] ? m1_rd_ctrl : m0_rd_ctrl;
  assign sel_wr   = gnt[1] ? m1_wr_ctrl : m0_wr_ctrl;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (gnt != GNT_NONE) begin
          grant_d = gnt;
          last_d  = gnt[1];
          addr_d  = sel_addr;
          din_d   = sel_din;
          cnt_d   = '0;
          dout_d  = '0;
          if (is_null_req(sel_rd, sel_wr)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            // write wins when both controls are set
            err_d   = 1'b0;
            wr_d    = sel_wr;
            rd_d    = (sel_wr != CTRL_NONE) ? CTRL_NONE : sel_rd;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_valid) begin
          dout_d  = (wr_q != CTRL_NONE) ? '0 : bus_dout;
          err_d   = 1'b0;
          rd_d    = CTRL_NONE;
          wr_d    = CTRL_NONE;
          state_d = RESP;
        end else if (cnt_q == CNT_TC) begin
          dout_d  = '0;
          err_d   = 1'b1;
          rd_d    = CTRL_NONE;
          wr_d    = CTRL_NONE;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        grant_d = GNT_NONE;
        cnt_d   = '0;
        rd_d    = CTRL_NONE;
        wr_d    = CTRL_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      last_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= CTRL_NONE;
      wr_q    <= CTRL_NONE;
      cnt_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign grant       = grant_q;
  assign bus_addr    = addr_q;
  assign bus_din     = din_q;
  assign bus_rd_ctrl = rd_q;
  assign bus_wr_ctrl = wr_q;

  assign m0_ack  = (state_q == RESP) && (grant_q == GNT_M0);
  assign m1_ack  = (state_q == RESP) && (grant_q == GNT_M1);
  assign m0_dout = m0_ack ? dout_q : '0;
  assign m1_dout = m1_ack ? dout_q : '0;
  assign m0_err  = m0_ack & err_q;
  assign m1_err  = m1_ack & err_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed scenarios followed by a
// randomized run against a transaction-level model of arbitration and timing.
module tb_sys_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [63:0] m0_addr, m1_addr, m0_din, m1_din;
  logic [2:0]  m0_rd_ctrl, m0_wr_ctrl, m1_rd_ctrl, m1_wr_ctrl;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [63:0] m0_dout, m1_dout;
  logic [63:0] bus_addr, bus_din, bus_dout;
  logic [2:0]  bus_rd_ctrl, bus_wr_ctrl;
  logic        bus_valid;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  logic        acks  [2];
  logic        errs  [2];
  logic [63:0] douts [2];
  assign acks[0]  = m0_ack;
  assign acks[1]  = m1_ack;
  assign errs[0]  = m0_err;
  assign errs[1]  = m1_err;
  assign douts[0] = m0_dout;
  assign douts[1] = m1_dout;

  // transaction-level model state for the random run
  logic        pend [2];
  logic [63:0] pa   [2];
  logic [63:0] pd   [2];
  logic [2:0]  pr   [2];
  logic [2:0]  pw   [2];

  sys_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_rd_ctrl(m0_rd_ctrl), .m0_wr_ctrl(m0_wr_ctrl),
    .m0_ack(m0_ack), .m0_dout(m0_dout), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_rd_ctrl(m1_rd_ctrl), .m1_wr_ctrl(m1_wr_ctrl),
    .m1_ack(m1_ack), .m1_dout(m1_dout), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_rd_ctrl(bus_rd_ctrl), .bus_wr_ctrl(bus_wr_ctrl),
    .bus_dout(bus_dout), .bus_valid(bus_valid), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_addr = '0; m0_din = '0; m0_rd_ctrl = 0; m0_wr_ctrl = 0;
    m1_req = 0; m1_addr = '0; m1_din = '0; m1_rd_ctrl = 0; m1_wr_ctrl = 0;
    bus_dout = '0; bus_valid = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (grant !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: grant=%b acks=%b%b, want 00 00", grant, m1_ack, m0_ack);
    end
    checks++;
    if (bus_rd_ctrl !== 3'b0 || bus_wr_ctrl !== 3'b0 || bus_addr !== 64'h0 || bus_din !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: rd=%h wr=%h addr=%h din=%h, want all 0", bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din);
    end
    checks++;
    if (m0_dout !== 64'h0 || m1_dout !== 64'h0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: dout0=%h dout1=%h err=%b%b, want 0", m0_dout, m1_dout, m1_err, m0_err);
    end
  endtask

  task automatic test_single_read;
    m0_req = 1; m0_addr = 64'h1000; m0_rd_ctrl = 3'b011; m0_wr_ctrl = 0;
    tick();
    checks++;
    if (grant !== 2'b01 || bus_addr !== 64'h1000 || bus_rd_ctrl !== 3'b011 || bus_wr_ctrl !== 3'b000) begin
      errors++;
      $display("FAIL single_bus: grant=%b addr=%h rd=%h wr=%h, want 01 1000 3 0", grant, bus_addr, bus_rd_ctrl, bus_wr_ctrl);
    end
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_early_ack: m0_ack=%b, want 0", m0_ack);
    end
    bus_valid = 1; bus_dout = 64'hDEAD_BEEF;
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_dout !== 64'hDEAD_BEEF || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack=%b dout=%h err=%b, want 1 deadbeef 0", m0_ack, m0_dout, m0_err);
    end
    bus_valid = 0; m0_req = 0;
    tick();
    checks++;
    if (m0_ack !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL single_after: ack=%b grant=%b, want 0 00", m0_ack, grant);
    end
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp_g;
    apply_reset();
    m0_req = 1; m0_addr = 64'hA0; m0_rd_ctrl = 3'b001;
    m1_req = 1; m1_addr = 64'hB0; m1_rd_ctrl = 3'b001;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if (grant !== exp_g || bus_addr !== (exp_g == 2'b01 ? 64'hA0 : 64'hB0)) begin
        errors++;
        $display("FAIL simul_order%0d: grant=%b addr=%h, want %b", i, grant, bus_addr, exp_g);
      end
      bus_valid = 1; bus_dout = 64'(i + 7);
      tick();
      checks++;
      if ({m1_ack, m0_ack} !== exp_g) begin
        errors++;
        $display("FAIL simul_ack%0d: acks=%b%b, want %b", i, m1_ack, m0_ack, exp_g);
      end
      bus_valid = 0;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout;
    int k;
    m1_req = 1; m1_addr = 64'h2000; m1_din = 64'h55; m1_wr_ctrl = 3'b010; m1_rd_ctrl = 0;
    tick();
    checks++;
    if (grant !== 2'b10 || bus_wr_ctrl !== 3'b010 || bus_din !== 64'h55) begin
      errors++;
      $display("FAIL timeout_bus: grant=%b wr=%h din=%h, want 10 2 55", grant, bus_wr_ctrl, bus_din);
    end
    k = 0;
    while (m1_ack !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (k !== TO) begin
      errors++;
      $display("FAIL timeout_cycles: busy cycles=%0d, want %0d", k, TO);
    end
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_dout !== 64'h0 || bus_wr_ctrl !== 3'b0) begin
      errors++;
      $display("FAIL timeout_resp: ack=%b err=%b dout=%h wr=%h, want 1 1 0 0", m1_ack, m1_err, m1_dout, bus_wr_ctrl);
    end
    m1_req = 0;
    tick();
    clear_inputs();
  endtask

  task automatic test_null;
    m0_req = 1; m0_addr = 64'h3000; m0_rd_ctrl = 0; m0_wr_ctrl = 0;
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_dout !== 64'h0) begin
      errors++;
      $display("FAIL null_ack: ack=%b err=%b dout=%h, want 1 1 0", m0_ack, m0_err, m0_dout);
    end
    checks++;
    if (bus_rd_ctrl !== 3'b0 || bus_wr_ctrl !== 3'b0) begin
      errors++;
      $display("FAIL null_bus: rd=%h wr=%h, want 0 0", bus_rd_ctrl, bus_wr_ctrl);
    end
    m0_req = 0;
    tick();
    checks++;
    if (m0_ack !== 1'b0 || bus_rd_ctrl !== 3'b0 || bus_wr_ctrl !== 3'b0) begin
      errors++;
      $display("FAIL null_after: ack=%b rd=%h wr=%h, want 0", m0_ack, bus_rd_ctrl, bus_wr_ctrl);
    end
  endtask

  task automatic test_both_ctrl;
    m0_req = 1; m0_addr = 64'h4000; m0_rd_ctrl = 3'b011; m0_wr_ctrl = 3'b011;
    tick();
    checks++;
    if (bus_rd_ctrl !== 3'b000 || bus_wr_ctrl !== 3'b011) begin
      errors++;
      $display("FAIL both_ctrl: rd=%h wr=%h, want 0 3", bus_rd_ctrl, bus_wr_ctrl);
    end
    bus_valid = 1; bus_dout = 64'h1234_5678;
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_dout !== 64'h0 || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL both_ctrl_ack: ack=%b dout=%h err=%b, want 1 0 0", m0_ack, m0_dout, m0_err);
    end
    bus_valid = 0; m0_req = 0;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy;
    m0_req = 1; m0_addr = 64'h5000; m0_rd_ctrl = 3'b001;
    tick();
    checks++;
    if (grant !== 2'b01 || bus_rd_ctrl !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_pre: grant=%b rd=%h, want 01 1", grant, bus_rd_ctrl);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || bus_rd_ctrl !== 3'b0 || bus_wr_ctrl !== 3'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: grant=%b rd=%h wr=%h ack=%b, want all 0", grant, bus_rd_ctrl, bus_wr_ctrl, m0_ack);
    end
    bus_valid = 1;
    tick();
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_noack: acks=%b%b grant=%b, want 0", m1_ack, m0_ack, grant);
    end
    clear_inputs();
    rst_n = 1;
    m1_req = 1; m1_addr = 64'h6000; m1_rd_ctrl = 3'b100;
    tick();
    checks++;
    if (grant !== 2'b10 || bus_addr !== 64'h6000 || bus_rd_ctrl !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_next: grant=%b addr=%h rd=%h, want 10 6000 4", grant, bus_addr, bus_rd_ctrl);
    end
    bus_valid = 1; bus_dout = 64'hCAFE;
    tick();
    checks++;
    if (m1_ack !== 1'b1 || m1_dout !== 64'hCAFE || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_next_ack: ack=%b dout=%h err=%b, want 1 cafe 0", m1_ack, m1_dout, m1_err);
    end
    bus_valid = 0; m1_req = 0;
    tick();
    clear_inputs();
  endtask

  task automatic gen_req(input int m);
    int kind;
    pend[m] = 1;
    pa[m]   = {$urandom, $urandom};
    pd[m]   = {$urandom, $urandom};
    pr[m]   = 3'($urandom_range(1, 7));
    pw[m]   = 3'($urandom_range(1, 7));
    kind    = $urandom_range(0, 7);
    if (kind == 0) begin
      pr[m] = 0; pw[m] = 0;
    end else if (kind < 4) begin
      pw[m] = 0;
    end else if (kind < 7) begin
      pr[m] = 0;
    end
  endtask

  task automatic test_random;
    int          last_m, w, d, k, exp_k;
    logic [1:0]  exp_g;
    logic [63:0] resp_data, exp_dout;
    logic        exp_err;
    apply_reset();
    last_m = 1;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1) gen_req(m);
      if (!pend[0] && !pend[1]) gen_req(int'($urandom_range(0, 1)));
      m0_req = pend[0]; m0_addr = pa[0]; m0_din = pd[0]; m0_rd_ctrl = pr[0]; m0_wr_ctrl = pw[0];
      m1_req = pend[1]; m1_addr = pa[1]; m1_din = pd[1]; m1_rd_ctrl = pr[1]; m1_wr_ctrl = pw[1];
      w     = (pend[0] && pend[1]) ? ((last_m == 0) ? 1 : 0) : (pend[0] ? 0 : 1);
      exp_g = (w == 0) ? 2'b01 : 2'b10;
      d     = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3);
      tick();
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL rand_grant it%0d: grant=%b, want %b", it, grant, exp_g);
      end
      if (pr[w] == 0 && pw[w] == 0) begin
        exp_k = 0; exp_err = 1; exp_dout = '0;
      end else begin
        checks++;
        if (bus_addr !== pa[w] || bus_din !== pd[w] || bus_wr_ctrl !== pw[w] ||
            bus_rd_ctrl !== ((pw[w] != 0) ? 3'b0 : pr[w])) begin
          errors++;
          $display("FAIL rand_bus it%0d: addr=%h din=%h rd=%h wr=%h, want %h %h rd%h wr%h", it,
                   bus_addr, bus_din, bus_rd_ctrl, bus_wr_ctrl, pa[w], pd[w], pr[w], pw[w]);
        end
        resp_data = '0;
        exp_k     = (d < TO) ? d + 1 : TO;
        exp_err   = (d >= TO);
        k = 0;
        while (acks[w] !== 1'b1 && k < 40) begin
          bus_valid = (k == d);
          bus_dout  = {$urandom, $urandom};
          if (k == d) resp_data = bus_dout;
          tick();
          k++;
        end
        bus_valid = 0;
        exp_dout  = (d < TO && pw[w] == 0) ? resp_data : 64'h0;
        checks++;
        if (k !== exp_k) begin
          errors++;
          $display("FAIL rand_latency it%0d: cycles=%0d, want %0d (delay %0d)", it, k, exp_k, d);
        end
      end
      checks++;
      if (acks[w] !== 1'b1 || acks[1-w] !== 1'b0 || errs[w] !== exp_err || douts[w] !== exp_dout) begin
        errors++;
        $display("FAIL rand_resp it%0d: ack=%b other=%b err=%b dout=%h, want 1 0 %b %h", it,
                 acks[w], acks[1-w], errs[w], douts[w], exp_err, exp_dout);
      end
      checks++;
      if (bus_rd_ctrl !== 3'b0 || bus_wr_ctrl !== 3'b0) begin
        errors++;
        $display("FAIL rand_resp_bus it%0d: rd=%h wr=%h, want 0 0", it, bus_rd_ctrl, bus_wr_ctrl);
      end
      pend[w] = 0;
      last_m  = w;
      if (w == 0) m0_req = 0; else m1_req = 0;
      bus_valid = 1'($urandom_range(0, 1));
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_timeout();
    test_null();
    test_both_ctrl();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
